// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      BYTE      = 2'd0,
      HALF_WORD = 2'd1,
      WORD      = 2'd2
   } ram_size_e;

   typedef enum logic {
      OWNER_IFETCH = 1'b0,
      OWNER_LSU    = 1'b1
   } arb_owner_e;

   function automatic logic [2:0] size_bytes(ram_size_e size);
      case (size)
         BYTE:      return 3'd1;
         HALF_WORD: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment and address-range check for one memory requester.
module mem_align_check
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic [31:0] addr_i,
   input  ram_size_e   size_i,
   output logic        err_o
);

   // 34-bit arithmetic so addresses near 2^32 cannot wrap past the limit
   localparam logic [33:0] LIMIT = 34'(MEM_SIZE) * 34'd4;

   logic [33:0] last_byte;
   logic        misaligned;

   always_comb begin
      last_byte  = {2'b00, addr_i} + {31'd0, size_bytes(size_i)} - 34'd1;
      misaligned = 1'b0;
      case (size_i)
         BYTE:      misaligned = 1'b0;
         HALF_WORD: misaligned = addr_i[0];
         default:   misaligned = |addr_i[1:0];
      endcase
      err_o = misaligned | (last_byte >= LIMIT);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter between instruction fetch and LSU onto a single
// combinational-read memory port, with fixed one-cycle response latency.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        ifetch_req_i,
   input  logic [31:0] ifetch_addr_i,
   output logic        ifetch_gnt_o,
   output logic        ifetch_rvalid_o,
   output logic        ifetch_err_o,
   output logic [31:0] ifetch_rdata_o,

   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic        lsu_unsigned_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  ram_size_e   lsu_size_i,
   output logic        lsu_gnt_o,
   output logic        lsu_rvalid_o,
   output logic        lsu_err_o,
   output logic [31:0] lsu_rdata_o,

   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   output ram_size_e   ram_size_o,
   output logic        ram_unsigned_o,
   output logic        ram_we_o,
   input  logic [31:0] ram_rdata_i
);

   arb_owner_e  last_owner_q, last_owner_d;
   logic        if_rvalid_q, if_rvalid_d;
   logic        if_err_q, if_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        lsu_rvalid_q, lsu_rvalid_d;
   logic        lsu_err_q, lsu_err_d;
   logic [31:0] lsu_rdata_q, lsu_rdata_d;

   logic        if_gnt, lsu_gnt;
   logic        if_addr_err, lsu_addr_err;

   mem_align_check #(.MEM_SIZE(MEM_SIZE)) u_ifetch_check (
      .addr_i (ifetch_addr_i),
      .size_i (WORD),
      .err_o  (if_addr_err)
   );

   mem_align_check #(.MEM_SIZE(MEM_SIZE)) u_lsu_check (
      .addr_i (lsu_addr_i),
      .size_i (lsu_size_i),
      .err_o  (lsu_addr_err)
   );

   always_comb begin
      if_gnt  = 1'b0;
      lsu_gnt = 1'b0;
      if (rst_ni) begin
         if (ifetch_req_i && (!lsu_req_i || last_owner_q == OWNER_LSU)) begin
            if_gnt = 1'b1;
         end else if (lsu_req_i) begin
            lsu_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr_o     = '0;
      ram_wdata_o    = '0;
      ram_size_o     = WORD;
      ram_unsigned_o = 1'b0;
      ram_we_o       = 1'b0;
      if (if_gnt) begin
         ram_addr_o = ifetch_addr_i;
      end else if (lsu_gnt) begin
         ram_addr_o     = lsu_addr_i;
         ram_wdata_o    = lsu_wdata_i;
         ram_size_o     = lsu_size_i;
         ram_unsigned_o = lsu_unsigned_i;
         ram_we_o       = lsu_we_i & ~lsu_addr_err;
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (if_gnt) begin
         last_owner_d = OWNER_IFETCH;
      end else if (lsu_gnt) begin
         last_owner_d = OWNER_LSU;
      end

      if_rvalid_d = if_gnt;
      if_err_d    = if_gnt ? if_addr_err : if_err_q;
      if_rdata_d  = if_rdata_q;
      if (if_gnt) begin
         if_rdata_d = if_addr_err ? '0 : ram_rdata_i;
      end

      lsu_rvalid_d = lsu_gnt;
      lsu_err_d    = lsu_gnt ? lsu_addr_err : lsu_err_q;
      lsu_rdata_d  = lsu_rdata_q;
      if (lsu_gnt) begin
         lsu_rdata_d = (lsu_addr_err || lsu_we_i) ? '0 : ram_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_owner_q <= OWNER_LSU;
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= '0;
         lsu_rvalid_q <= 1'b0;
         lsu_err_q    <= 1'b0;
         lsu_rdata_q  <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         if_rvalid_q  <= if_rvalid_d;
         if_err_q     <= if_err_d;
         if_rdata_q   <= if_rdata_d;
         lsu_rvalid_q <= lsu_rvalid_d;
         lsu_err_q    <= lsu_err_d;
         lsu_rdata_q  <= lsu_rdata_d;
      end
   end

   // A response already in flight when reset asserts is suppressed, not delivered
   assign ifetch_gnt_o    = if_gnt;
   assign ifetch_rvalid_o = if_rvalid_q & rst_ni;
   assign ifetch_err_o    = if_err_q;
   assign ifetch_rdata_o  = if_rdata_q;
   assign lsu_gnt_o       = lsu_gnt;
   assign lsu_rvalid_o    = lsu_rvalid_q & rst_ni;
   assign lsu_err_o       = lsu_err_q;
   assign lsu_rdata_o     = lsu_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 4096, memory depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_SIZE-1.
REQ-002 clk_i  input  1  single clock; all state changes on posedge clk_i.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 ifetch_req_i  input  1  instruction-fetch request; held stable until granted.
REQ-005 ifetch_addr_i  input  32  fetch byte address; access is always a WORD.
REQ-006 ifetch_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 ifetch_rvalid_o / ifetch_err_o  output  1/1  fetch response valid / fetch error.
REQ-008 ifetch_rdata_o  output  32  fetched word.
REQ-009 lsu_req_i, lsu_we_i, lsu_unsigned_i  input  1 each  load/store request, write select, zero-extend select.
REQ-010 lsu_addr_i, lsu_wdata_i  input  32 each  byte address and store data.
REQ-011 lsu_size_i  input  ram_size_e  BYTE, HALF_WORD or WORD.
REQ-012 lsu_gnt_o, lsu_rvalid_o, lsu_err_o  output  1 each  grant, response valid, error.
REQ-013 lsu_rdata_o  output  32  load data; 0 on store or error responses.
REQ-014 ram_addr_o, ram_wdata_o  output  32 each  memory address and write data.
REQ-015 ram_size_o, ram_unsigned_o, ram_we_o  output  ram_size_e/1/1  memory size, extension select, write enable.
REQ-016 ram_rdata_i  input  32  combinational, already size-extended memory read data.

Function
REQ-017 Each cycle, at most one requester SHALL be granted; the grant is combinational in the request cycle N.
REQ-018 Only one requester asserting req: that requester SHALL be granted.
REQ-019 Both requesters asserting req: the requester not granted most recently SHALL be granted (2-way round-robin).
REQ-020 A last_owner register SHALL record the most recent grant; its reset value is LSU, so the first contended grant goes to ifetch.
REQ-021 In cycle N, ram_* SHALL carry the granted request: fetch → size WORD, unsigned 0, we 0; LSU → its own fields.
REQ-022 With no grant, ram_we_o SHALL be 0 and ram_addr_o/ram_wdata_o SHALL be 0.
REQ-023 An error SHALL be raised for: HALF_WORD with addr[0]=1; WORD or fetch with addr[1:0]!=0; any access where addr+size-1 >= 4*MEM_SIZE.
REQ-024 An erroneous request SHALL still be granted, with ram_we_o forced to 0.
REQ-025 Granted in cycle N, the owner's rvalid SHALL pulse high for exactly cycle N+1; latency is fixed at 1.
REQ-026 rdata SHALL be ram_rdata_i registered at the end of cycle N; it is 0 for stores or errors.
REQ-027 err SHALL accompany rvalid in cycle N+1 whenever REQ-023 applied.
REQ-028 Back-to-back grants every cycle SHALL be supported, including alternating owners under contention.
REQ-029 Example: a store granted in N followed by a load to the same address in N+1 SHALL return the stored data.
REQ-030 A requester's rdata SHALL hold its last value while its rvalid is low.
REQ-031 The ungranted requester's rvalid, rdata and err SHALL be unaffected in cycle N+1.

Reset
REQ-032 While rst_ni=0 at a clock edge, all registers SHALL load their reset values: rvalids 0, errs 0, rdatas 0, last_owner LSU.
REQ-033 While rst_ni=0, gnt_o and ram_we_o SHALL be held 0 combinationally.
REQ-034 A response pending from a grant in the cycle before reset SHALL be dropped; no rvalid follows reset release.

Structure
REQ-035 The types package SHALL gain arb_owner_e {OWNER_IFETCH, OWNER_LSU}; ram_size_e is reused from it.
REQ-036 The misalignment and range check SHALL live in a combinational sub-module mem_align_check (addr, size, MEM_SIZE → err), instantiated once per requester.

Verification
REQ-037 Reset: with rst_ni=0 and both req=1, all gnt, rvalid and ram_we_o are 0; the first cycle after release grants ifetch.
REQ-038 Contention: both req held for 4 cycles → grants alternate I,L,I,L; each rvalid follows its grant by 1 cycle.
REQ-039 LSU WORD store 0xDEADBEEF @0x100, then fetch @0x100 → ifetch_rdata_o=0xDEADBEEF, err 0.
REQ-040 Byte 0x80 stored @0x7; signed BYTE load → 0xFFFFFF80; unsigned → 0x00000080.
REQ-041 HALF_WORD store @0x3 → granted, ram_we_o 0, lsu_err_o 1 at N+1; WORD load @0x3FFC ok, @0x4000 → err.
REQ-042 Reset asserted in cycle N+1 after an LSU grant in N → lsu_rvalid_o stays 0 after release.
